// File: rtl/result_stream_tx.sv
// result_stream_tx: drain end of the 4x4 systolic array.
// Re-aligns the time-staggered result lanes into 32-bit words and buffers them
// in a first-word-fall-through FIFO. The words leave on an AXI4-Stream master
// port, and TLAST marks every PKT_LEN-th beat.
// The array cannot be stalled. A word that arrives while the FIFO is full is
// dropped, and the sticky overflow flag records the loss.
// Optional build macro RESULT_TX_STALL_EN adds a registered res_stall output.
// res_stall warns the upstream sequencer before the FIFO can overflow.
module result_stream_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PKT_LEN    = 4
) (
  input  logic                         axi_clk,
  input  logic                         axi_rst,
  input  logic [31:0]                  res_data,
  input  logic                         res_valid,
  output logic [31:0]                  m_axis_data,
  output logic                         m_axis_valid,
  input  logic                         m_axis_ready,
  output logic                         m_axis_last,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow
`ifdef RESULT_TX_STALL_EN
  ,
  output logic                         res_stall
`endif
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned CNT_W  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  // De-skew delay lines: lane3 three deep, lane2 two deep, lane1 one deep
  logic [3*LANE_W-1:0] lane3_q, lane3_d;
  logic [2*LANE_W-1:0] lane2_q, lane2_d;
  logic [LANE_W-1:0]   lane1_q, lane1_d;
  logic [2:0]          vld_q, vld_d;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    beat_q, beat_d;

  logic [DATA_W-1:0]   word_c;
  logic                wr_en_c;
  logic                full_c;
  logic                not_empty_c;
  logic                pop_c;
  logic                push_c;
  logic                drop_c;

  // Next state of the de-skew shift registers and the valid chain
  always_comb begin
    lane3_d = {lane3_q[2*LANE_W-1:0], res_data[31:24]};
    lane2_d = {lane2_q[LANE_W-1:0], res_data[23:16]};
    lane1_d = res_data[15:8];
    vld_d   = {vld_q[1:0], res_valid};
  end

  // Aligned word and its write strobe, both three cycles after res_valid
  always_comb begin
    word_c  = {lane3_q[3*LANE_W-1:2*LANE_W], lane2_q[2*LANE_W-1:LANE_W],
               lane1_q, res_data[7:0]};
    wr_en_c = vld_q[2];
  end

  // FIFO push/pop decisions, pointer, level, overflow and beat-counter updates
  always_comb begin
    full_c      = (level_q == LVL_W'(FIFO_DEPTH));
    not_empty_c = (level_q != '0);
    pop_c       = not_empty_c && m_axis_ready;
    // A full FIFO still accepts a word when the head leaves on the same edge
    push_c      = wr_en_c && (!full_c || pop_c);
    drop_c      = wr_en_c && full_c && !pop_c;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    beat_d   = beat_q;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (beat_q == CNT_W'(PKT_LEN - 1)) begin
        beat_d = '0;
      end else begin
        beat_d = beat_q + CNT_W'(1);
      end
    end

    unique case ({push_c, pop_c})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop_c) begin
      ovf_d = 1'b1;
    end
  end

  // Pipeline and control registers
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      lane3_q  <= '0;
      lane2_q  <= '0;
      lane1_q  <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      beat_q   <= '0;
    end else begin
      lane3_q  <= lane3_d;
      lane2_q  <= lane2_d;
      lane1_q  <= lane1_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      beat_q   <= beat_d;
    end
  end

  // FIFO storage array; contents are don't-care while level is zero
  always_ff @(posedge axi_clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= word_c;
    end
  end

  // Stream outputs; data is forced to zero whenever no word is presented
  always_comb begin
    m_axis_valid = not_empty_c;
    m_axis_data  = not_empty_c ? mem_q[rd_ptr_q] : '0;
    m_axis_last  = not_empty_c && (beat_q == CNT_W'(PKT_LEN - 1));
    fifo_level   = level_q;
    overflow     = ovf_q;
  end

`ifdef RESULT_TX_STALL_EN
  logic stall_q, stall_d;

  // Upstream stall request. Four free slots cover the three words still in
  // the de-skew pipeline plus one word issued while res_stall propagates.
  always_comb begin
    stall_d = (level_q >= LVL_W'(FIFO_DEPTH - 4));
  end

  // Stall register
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign res_stall = stall_q;
`endif

endmodule

// File: tb/tb_result_stream_tx.sv
// Bench for result_stream_tx.
// The bench builds the skewed lane stream from whole words. It scoreboards
// each word when that word is issued, and checks each beat as the word leaves
// on AXI4-Stream.
module tb_result_stream_tx;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned PKT_LEN    = 4;

  logic                        axi_clk;
  logic                        axi_rst;
  logic [31:0]                 res_data;
  logic                        res_valid;
  logic [31:0]                 m_axis_data;
  logic                        m_axis_valid;
  logic                        m_axis_ready;
  logic                        m_axis_last;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        overflow;
`ifdef RESULT_TX_STALL_EN
  logic                        res_stall;
`endif

  result_stream_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PKT_LEN    (PKT_LEN)
  ) dut (
    .axi_clk      (axi_clk),
    .axi_rst      (axi_rst),
    .res_data     (res_data),
    .res_valid    (res_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
`ifdef RESULT_TX_STALL_EN
    ,
    .res_stall    (res_stall)
`endif
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_q [$];
  int          exp_beat = 0;
  logic [31:0] sk_w [4];
  bit          sk_v [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Issue one cycle of skewed input. A word started j cycles ago supplies
  // lane 3-j. Lanes not owned by any word carry random filler.
  task automatic cycle(input bit v, input logic [31:0] w, input bit keep);
    logic [31:0] fill;
    for (int j = 3; j > 0; j--) begin
      sk_w[j] = sk_w[j-1];
      sk_v[j] = sk_v[j-1];
    end
    sk_w[0] = w;
    sk_v[0] = v;
    fill = $urandom();
    res_valid = v;
    res_data[31:24] = sk_v[0] ? sk_w[0][31:24] : fill[31:24];
    res_data[23:16] = sk_v[1] ? sk_w[1][23:16] : fill[23:16];
    res_data[15:8]  = sk_v[2] ? sk_w[2][15:8]  : fill[15:8];
    res_data[7:0]   = sk_v[3] ? sk_w[3][7:0]   : fill[7:0];
    if (v && keep) exp_q.push_back(w);
    @(posedge axi_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0);
  endtask

  // One-cycle reset pulse; every output must read zero while it is asserted
  task automatic do_reset();
    axi_rst   = 1'b1;
    res_valid = 1'b0;
    for (int j = 0; j < 4; j++) sk_v[j] = 1'b0;
    exp_q.delete();
    @(posedge axi_clk);
    #1;
    check("rst_valid", 32'(m_axis_valid), 32'd0);
    check("rst_last",  32'(m_axis_last),  32'd0);
    check("rst_data",  m_axis_data,       32'd0);
    check("rst_level", 32'(fifo_level),   32'd0);
    check("rst_ovf",   32'(overflow),     32'd0);
`ifdef RESULT_TX_STALL_EN
    check("rst_stall", 32'(res_stall),    32'd0);
`endif
    axi_rst = 1'b0;
  endtask

  // Beat monitor: compares each handshake against the scoreboard and the packet model
  always @(negedge axi_clk) begin
    if (axi_rst) begin
      exp_beat = 0;
    end else if (m_axis_valid && m_axis_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("beat_data", m_axis_data, e);
        check("beat_last", 32'(m_axis_last), 32'(exp_beat == int'(PKT_LEN) - 1));
        exp_beat = (exp_beat == int'(PKT_LEN) - 1) ? 0 : exp_beat + 1;
      end
    end
  end

  initial begin
    logic [31:0] w0;
    axi_rst      = 1'b1;
    res_valid    = 1'b0;
    res_data     = '0;
    m_axis_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      sk_w[j] = '0;
      sk_v[j] = 1'b0;
    end
    #12;
    do_reset();

    // Single word with latency check
    m_axis_ready = 1'b1;
    cycle(1'b1, 32'hAABBCCDD, 1'b1);
    idle(2);
    check("lat_t3_valid", 32'(m_axis_valid), 32'd0);
    idle(1);
    check("lat_t4_valid", 32'(m_axis_valid), 32'd1);
    check("lat_t4_data",  m_axis_data,       32'hAABBCCDD);
    idle(1);
    check("single_valid_off", 32'(m_axis_valid), 32'd0);
    check("single_level",     32'(fifo_level),   32'd0);

    // Back-to-back streaming, TLAST on beats 3 and 7
    do_reset();
    m_axis_ready = 1'b1;
    for (int k = 0; k < 8; k++) cycle(1'b1, {4{8'(k)}}, 1'b1);
    idle(14);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure to full, then one dropped word
    do_reset();
    m_axis_ready = 1'b0;
    for (int k = 0; k < 8; k++) cycle(1'b1, $urandom(), 1'b1);
    w0 = exp_q[0];
    idle(3);
    check("bp_level", 32'(fifo_level), 32'd8);
    check("bp_ovf",   32'(overflow),   32'd0);
    check("bp_head",  m_axis_data,     w0);
    idle(1);
    check("bp_head_stable", m_axis_data, w0);
    cycle(1'b1, $urandom(), 1'b0);
    idle(3);
    check("ovf_set",   32'(overflow),   32'd1);
    check("ovf_level", 32'(fifo_level), 32'd8);
    m_axis_ready = 1'b1;
    idle(12);
    check("bp_drained",  32'(exp_q.size()), 32'd0);
    check("ovf_sticky",  32'(overflow),     32'd1);
    check("bp_level_0",  32'(fifo_level),   32'd0);

    // Full FIFO with a push and a pop on the same edge
    do_reset();
    m_axis_ready = 1'b0;
    for (int k = 0; k < 8; k++) cycle(1'b1, $urandom(), 1'b1);
    idle(3);
    check("fp_level_pre", 32'(fifo_level), 32'd8);
    cycle(1'b1, 32'hC0FFEE99, 1'b1);
    idle(2);
    m_axis_ready = 1'b1;
    idle(1);
    m_axis_ready = 1'b0;
    check("fp_level", 32'(fifo_level), 32'd8);
    check("fp_ovf",   32'(overflow),   32'd0);
    m_axis_ready = 1'b1;
    idle(12);
    check("fp_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a packet while overflow is set
    do_reset();
    m_axis_ready = 1'b0;
    for (int k = 0; k < 8; k++) cycle(1'b1, $urandom(), 1'b1);
    cycle(1'b1, $urandom(), 1'b0);
    idle(3);
    check("mid_ovf_pre", 32'(overflow), 32'd1);
    m_axis_ready = 1'b1;
    idle(2);
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h5A000000 + 32'(k), 1'b1);
    idle(8);
    check("mid_drained", 32'(exp_q.size()), 32'd0);

`ifdef RESULT_TX_STALL_EN
    // An upstream that obeys res_stall never overflows the FIFO
    do_reset();
    m_axis_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check("stall_track", 32'(res_stall), 32'(c >= 8));
      if (c < 8) cycle(1'b1, $urandom(), 1'b1);
      else       idle(1);
    end
    check("stall_level", 32'(fifo_level), 32'd8);
    check("stall_ovf",   32'(overflow),   32'd0);
    m_axis_ready = 1'b1;
    idle(12);
    check("stall_drained", 32'(exp_q.size()), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/result_stream_tx.md
Name: result_stream_tx

Overview:
- Drain end of the 4x4 systolic array: collects time-staggered result lanes, de-skews them into aligned 32-bit words, and buffers them in a FIFO.
- Sends the words to the DMA over an AXI4-Stream master, with TLAST framing.
- The array is free-running and cannot be back-pressured, so the FIFO absorbs m_axis_ready stalls. Overflow is flagged, never silently hidden.

Parameters:
- FIFO_DEPTH, 8, number of 32-bit words buffered; power of 2, >= 4.
- PKT_LEN, 4, beats per AXI4-S packet (TLAST on last beat); >= 1.

Ports:
- axi_clk  in  1  sole clock, rising edge.
- axi_rst  in  1  asynchronous, active-high reset.
- res_data  in  32  skewed array outputs; lane3=[31:24], lane2=[23:16], lane1=[15:8], lane0=[7:0].
- res_valid  in  1  marks the cycle lane3 of a result word is valid.
- m_axis_data  out  32  aligned result word.
- m_axis_valid  out  1  AXI4-S TVALID.
- m_axis_ready  in  1  AXI4-S TREADY.
- m_axis_last  out  1  AXI4-S TLAST.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently held.
- overflow  out  1  sticky: a word was dropped.

Behaviour:
- Reset (async, active-high): all outputs 0, FIFO empty, de-skew and valid pipelines 0, beat counter 0, overflow 0. Asserting reset mid-packet discards all in-flight and buffered data. The first beat after reset starts a new packet.
- Input skew: for a word whose res_valid is at cycle t:
  - lane3 is on res_data at t
  - lane2 is on res_data at t+1
  - lane1 is on res_data at t+2
  - lane0 is on res_data at t+3
- De-skew:
  - lane3 delayed 3 registers, lane2 delayed 2, lane1 delayed 1, lane0 taken direct.
  - The aligned word is formed combinationally in cycle t+3.
  - res_valid passes through a 3-stage register chain to give wr_en at t+3.
  - Back-to-back res_valid every cycle is supported. Lanes of adjacent words overlap on res_data and must not corrupt each other.
- FIFO write: on the axi_clk edge ending cycle t+3 when wr_en=1.
  - Not full: word stored, level+1.
  - Full and no pop in the same cycle: word dropped, level unchanged, overflow set to 1 and held until reset.
  - Full and pop in the same cycle: write accepted, level unchanged.
- FIFO read (first-word-fall-through):
  - m_axis_valid = (level != 0).
  - m_axis_data = head word, stable while valid && !ready.
  - Pop on valid && ready.
- Latency: 4 cycles, from res_valid at t to m_axis_valid high at t+4, when the FIFO is empty.
- Framing:
  - The beat counter increments on each handshake and wraps to 0 after PKT_LEN-1.
  - m_axis_last = m_axis_valid && (count == PKT_LEN-1).
  - PKT_LEN=1 makes every beat last.
  - Stalls do not advance the counter.
- Pointers: wrap modulo FIFO_DEPTH. fifo_level is an up/down counter, range 0..FIFO_DEPTH.
- Simultaneous push+pop with FIFO empty: the push succeeds. The popped word is not the pushed one, because valid was low, so no pop occurs that cycle.
- Data ordering is preserved end to end; no reordering.

Optional Feature:
- Macro RESULT_TX_STALL_EN.
- Defined: adds output port res_stall (1 bit, reset 0).
  - res_stall is registered and high when fifo_level >= FIFO_DEPTH-4.
  - Upstream sequencing uses it to stop issuing array passes.
  - The 3-word de-skew pipeline plus 1 cycle of response slack then always fit, so no overflow occurs if the sequencer obeys it.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Single word, ready=1:
  - Stimulus: res_valid at t; res_data lane3=0xAA at t, lane2=0xBB at t+1, lane1=0xCC at t+2, lane0=0xDD at t+3.
  - Response: m_axis_data=0xAABBCCDD with valid at t+4, for 1 cycle; level back to 0.
- Streaming: 8 back-to-back words, word k lanes all 8'hk, ready=1.
  - Response: 8 consecutive beats 0x00000000..0x07070707 in order.
  - m_axis_last on beats 3 and 7.
- Back-pressure: ready=0, push 8 words.
  - Response: fifo_level=8, overflow=0, head stable.
  - Push a 9th word: overflow=1, level stays 8.
  - Release ready: words 0..7 emerge; the 9th never appears.
- Full with simultaneous pop: FIFO at 8; push at the same cycle ready=1.
  - Response: level stays 8, no overflow, new word appears after the 7 older words.
- Reset mid-packet: after 2 of 4 beats, pulse axi_rst for 1 cycle.
  - Response: all outputs 0, overflow cleared.
  - Next 4 words form a fresh packet, TLAST on the 4th.
- Feature build (RESULT_TX_STALL_EN), FIFO_DEPTH=8, ready=0:
  - res_stall rises the cycle after level reaches 4.
  - Stopping res_valid then yields a final level <= 8 with overflow=0.
